// File: rtl/shift_add_mult32.sv
// shift_add_mult32: sequential 32x32 unsigned shift-and-add multiplier wrapped around a 64-bit CLA.
// Optional build macro MULT_EARLY_EXIT_EN lets RUN finish once the remaining multiplier bits are zero.

module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        p_out,
  output logic        g_out
);

  function automatic logic [3:0] carry4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [63:0] bit_g, bit_p, bit_c;
  logic [15:0] grp_g, grp_p, grp_c;
  logic [3:0]  sup_g, sup_p, sup_c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Three lookahead levels: 16 nibble groups, 4 super-groups, then the top carry.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      grp_g[k] = grp_gen(bit_g[4*k +: 4], bit_p[4*k +: 4]);
      grp_p[k] = &bit_p[4*k +: 4];
    end
  end

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      sup_g[s] = grp_gen(grp_g[4*s +: 4], grp_p[4*s +: 4]);
      sup_p[s] = &grp_p[4*s +: 4];
    end
  end

  assign sup_c = carry4(sup_g, sup_p, cin);

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      grp_c[4*s +: 4] = carry4(grp_g[4*s +: 4], grp_p[4*s +: 4], sup_c[s]);
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      bit_c[4*k +: 4] = carry4(bit_g[4*k +: 4], bit_p[4*k +: 4], grp_c[k]);
    end
  end

  assign g_out = grp_gen(sup_g, sup_p);
  assign p_out = &sup_p;
  assign cout  = g_out | (p_out & cin);
  assign sum   = bit_p ^ bit_c;

endmodule

module shift_add_mult32 #(
  parameter int OPW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [OPW-1:0]     a,
  input  logic [OPW-1:0]     b,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [2*OPW-1:0]   product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [2*OPW-1:0] mcand;
  logic [OPW-1:0]   mplier;
  logic [2*OPW-1:0] acc;
  logic [5:0]       cnt;
  logic [2*OPW-1:0] adder_sum;
  logic             last_iter;
  logic             unused_cout, unused_p, unused_g;

  CLA_64bit u_adder (
    .a     (acc),
    .b     (mcand),
    .cin   (1'b0),
    .sum   (adder_sum),
    .cout  (unused_cout),
    .p_out (unused_p),
    .g_out (unused_g)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Stop once nothing is left to add after this shift; cnt still caps the worst case.
  assign last_iter = (mplier[OPW-1:1] == '0) || (cnt == 6'(OPW-1));
`else
  assign last_iter = (cnt == 6'(OPW-1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start_valid) next_state = RUN;
      RUN:  if (last_iter)   next_state = DONE;
      DONE: if (done_ready)  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    unique case (state)
      IDLE:    start_ready = 1'b1;
      RUN:     busy        = 1'b1;
      DONE: begin
        done_valid = 1'b1;
        busy       = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
  end

  // acc keeps the finished product through DONE and IDLE until the next accept clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            mcand  <= {{OPW{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= adder_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_shift_add_mult32.sv
// Self-checking bench for shift_add_mult32: vector table plus backpressure and mid-run reset sequences.
// Expected latency follows MULT_EARLY_EXIT_EN when the bench is built with it.

module tb_shift_add_mult32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        done_valid;
  logic        done_ready;
  logic [63:0] product;
  logic        busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  vec_t        vecs[10];
  logic [31:0] ra, rb;
  int          seen;

  always #5 clk = ~clk;

  shift_add_mult32 dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .product     (product),
    .busy        (busy)
  );

  function automatic int exp_latency(input logic [31:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) k = i + 1;
    return k;
`else
    return (bv == bv) ? 32 : 32;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
  endtask

  // Scoreboard: every product handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done_valid && done_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_product: actual=%h expected=none", product);
      end else begin
        checkOutput("product", product, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] ai, input logic [31:0] bi, input logic [63:0] prod);
    int w = 0;
    @(negedge clk);
    while (!start_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!start_ready) checkOutput("start_ready_timeout", {63'b0, start_ready}, 64'd1);
    a           = ai;
    b           = bi;
    start_valid = 1'b1;
    exp_q.push_back(prod);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checkOutput("busy_after_accept", {63'b0, busy}, 64'd1);
    checkOutput("start_ready_in_run", {63'b0, start_ready}, 64'd0);
  endtask

  task automatic waitDone(input int exp_lat);
    int  lat = 0;
    logic got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_valid) got = 1'b1;
    end
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    if (done_ready) begin
      @(posedge clk);
      #1;
      checkOutput("done_valid_one_cycle", {63'b0, done_valid}, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    #1;
    checkOutput("reset_start_ready", {63'b0, start_ready}, 64'd1);
    checkOutput("reset_done_valid", {63'b0, done_valid}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_product", product, 64'd0);

    vecs[0] = '{32'd3,         32'd5,         64'h000000000000000F};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001};
    vecs[2] = '{32'hDEADBEEF,  32'd1,         64'h00000000DEADBEEF};
    vecs[3] = '{32'd2,         32'h80000000,  64'h0000000100000000};
    vecs[4] = '{32'hDEADBEEF,  32'd0,         64'h0000000000000000};
    vecs[5] = '{32'd0,         32'hFFFFFFFF,  64'h0000000000000000};
    vecs[6] = '{32'h00010000,  32'h00010000,  64'h0000000100000000};
    vecs[7] = '{32'hFFFFFFFF,  32'd2,         64'h00000001FFFFFFFE};
    vecs[8] = '{32'h12345678,  32'h9ABCDEF0,  64'h0B00EA4E242D2080};
    vecs[9] = '{32'd6,         32'd7,         64'd42};

    @(negedge clk);
    rst        = 1'b0;
    done_ready = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod);
      waitDone(exp_latency(vecs[i].b));
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ra, rb, {32'b0, ra} * {32'b0, rb});
      waitDone(exp_latency(rb));
    end

    // Backpressure: product must hold while a new start request is refused.
    done_ready = 1'b0;
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);
    waitDone(exp_latency(32'h9ABCDEF0));
    a           = 32'd6;
    b           = 32'd7;
    start_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("held_product", product, 64'h0B00EA4E242D2080);
      checkOutput("held_done_valid", {63'b0, done_valid}, 64'd1);
      checkOutput("no_accept_in_done", {63'b0, start_ready}, 64'd0);
    end
    exp_q.push_back(64'd42);
    @(posedge clk);
    #1;
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_after_handoff", {63'b0, start_ready}, 64'd1);
    checkOutput("idle_busy", {63'b0, busy}, 64'd0);
    checkOutput("product_kept_idle", product, 64'h0B00EA4E242D2080);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checkOutput("accept_after_handoff", {63'b0, busy}, 64'd1);
    checkOutput("product_cleared", product, 64'd0);
    waitDone(exp_latency(32'd7));

    // Reset pulsed during the 10th RUN cycle discards the in-flight result.
    applyStimulus(32'd7, 32'd9, 64'd63);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_start_ready", {63'b0, start_ready}, 64'd1);
    checkOutput("midrun_reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("midrun_reset_product", product, 64'd0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_valid) seen++;
    end
    checkOutput("no_done_after_reset", 64'(seen), 64'd0);
    applyStimulus(32'd6, 32'd7, 64'd42);
    waitDone(exp_latency(32'd7));

    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult32.md
# shift_add_mult32

Sequential 32x32 unsigned shift-and-add multiplier built around the team's 64-bit carry-lookahead adder (`CLA_64bit`, carry-in tied 0). It sits directly upstream of that adder: each cycle it presents a 64-bit partial-product accumulator and a shifted multiplicand, then registers the sum. It accepts operand pairs over a valid/ready handshake and returns a 64-bit product over a second valid/ready handshake.

## Interface
- `OPW`, 32, operand width; only 32 is supported (product width 2*OPW matches the 64-bit adder).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  operands `a`/`b` are valid.
- `start_ready`  out  1  block is idle and accepts operands.
- `a`  in  32  multiplicand, unsigned.
- `b`  in  32  multiplier, unsigned.
- `done_valid`  out  1  `product` is valid.
- `done_ready`  in  1  consumer takes `product`.
- `product`  out  64  result `a*b`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `mcand` (64b)
  - `mplier` (32b)
  - `acc` (64b, drives `product`)
  - `cnt` (6b)
- IDLE:
  - `start_ready`=1.
  - On `start_valid && start_ready`: `mcand`={32'b0,a}; `mplier`=b; `acc`=0; `cnt`=0; go to RUN.
- RUN (one iteration per cycle):
  - Adder inputs are `acc` and `mcand`, cin=0.
  - If `mplier[0]`, `acc` <= adder sum; else `acc` holds.
  - `mcand` <<= 1; `mplier` >>= 1; `cnt`++.
  - When the iteration just performed has `cnt`==31, go to DONE.
- Arithmetic: the maximum shift is 31, so no `mcand` bit passes bit 63. The sum never exceeds 2^64-1, so adder carry-out and group P/G outputs are unused.
- DONE:
  - `done_valid`=1.
  - `product` is held stable until `done_ready` is sampled high, then go to IDLE.
- `start_ready`=0 in RUN and DONE; `start_valid` is ignored there. No queueing.
- `done_ready` is ignored outside DONE.
- DONE handoff and a new `start_valid` on the same edge: the handoff completes and the start is accepted on the next edge (IDLE).
- `product` keeps the last result in IDLE. It is cleared on the next acceptance.

## Timing
- Reset values:
  - state IDLE
  - `start_ready`=1
  - `done_valid`=0
  - `busy`=0
  - `product`=0
  - `mcand`/`mplier`/`cnt`=0
- `rst` asserted mid-RUN or in DONE forces IDLE immediately (asynchronously). The in-flight result is discarded and `done_valid` never rises for it.
- Latency: `done_valid` rises 32 clock edges after the accepting edge (macro off).
- Throughput: one operation per 34 cycles minimum (accept + 32 RUN + DONE with `done_ready`=1, then IDLE).
- All outputs are registered or decoded from the state register. There is no combinational path from `start_valid`/`done_ready` to outputs.

## Configuration
- `MULT_EARLY_EXIT_EN`:
  - Defined: RUN exits to DONE after the iteration in which the shifted `mplier` becomes 0. Iterations k = (index of highest set bit of b)+1, with b=0 giving k=1, so `done_valid` rises k edges after accept.
  - Undefined: always 32 iterations; the `cnt` compare is the only exit.
  - Results are identical either way.

## Test plan
- Reset check: assert `rst` at time 0 -> `start_ready`=1, `done_valid`=0, `busy`=0, `product`=0.
- a=3, b=5, `done_ready`=1 (macro off) -> `product`=64'h000000000000000F; `done_valid` rises exactly 32 edges after accept and holds 1 cycle.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> `product`=64'hFFFFFFFE00000001.
- Backpressure:
  - Stimulus: a=32'h12345678, b=32'h9ABCDEF0; `done_ready`=0 for 10 cycles; `start_valid`=1 with new operands during that time.
  - Response: `product`=64'h0B00EA4E242D2080 held stable; new operands not accepted until the cycle after the handoff.
- Reset mid-run: `rst` pulsed on the 10th RUN cycle of a=7, b=9 -> IDLE, no `done_valid`; the next operation a=6, b=7 gives `product`=42.
- `MULT_EARLY_EXIT_EN` defined:
  - b=1 -> `done_valid` 1 edge after accept, `product`=a.
  - b=32'h80000000, a=2 -> 32 edges, `product`=64'h0000000100000000.
  - b=0 -> 1 edge, `product`=0.
